vinsn_launcher: RTL and testbench
=================================

Name: vinsn_launcher

Overview:
- Sits directly downstream of the vector instruction decoder and takes decoded issue_req_t requests over a valid/ready handshake.
- Holds one request in a pending register and checks it against a scoreboard of in-flight instructions for RAW/WAR/WAW vector-register hazards.
- Dispatches the hazard-free request to the arithmetic, load or store unit, and retires scoreboard entries when units report completion by insn_id.

Parameters:
- NrInflight, 4, number of scoreboard entries (max in-flight vector instructions); must be ≥ 1.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  1  decoded request valid
- req_ready_o  out  1  launcher can accept request
- issue_req_i  in  $bits(issue_req_t)  decoded request
- arith_valid_o  out  1  dispatch to arithmetic unit
- arith_ready_i  in  1  arithmetic unit accepts
- load_valid_o  out  1  dispatch to load unit
- load_ready_i  in  1  load unit accepts
- store_valid_o  out  1  dispatch to store unit
- store_ready_i  in  1  store unit accepts
- uop_o  out  $bits(issue_req_t)  request being dispatched (shared by all three units)
- done_valid_i  in  3  completion strobe per unit: [0] arith, [1] load, [2] store
- done_id_i  in  3 x $bits(insn_id_t)  insn_id of the completing instruction, per unit
- busy_o  out  1  pending valid or any scoreboard entry valid

Behaviour:
- Reset (async, rst_ni low): pending_valid=0, all scoreboard entries invalid. Outputs are then req_ready_o=1, all *_valid_o=0, busy_o=0, uop_o=0.
- Pending register:
  - Request is captured on req_valid_i && req_ready_o.
  - req_ready_o = !pending_valid || dispatch_fire. This gives back-to-back acceptance with no bubble.
  - Capture and dispatch in the same cycle replace the pending register.
- Target unit select:
  - vop==VLE → load.
  - vop==VSE → store.
  - all other vop values → arith.
- Hazard, computed combinationally from the pending request against every valid entry e:
  - RAW: pending use_vs[VS1] && vs[VS1]==e.vd && e.use_vs[VD]. Same check for VS2.
  - WAR: pending use_vs[VD] && e.use_vs[VSx] && e.vs[VSx]==pending vs[VD].
  - WAW: both use_vs[VD] && vd equal.
  - Any match stalls the request.
- Dispatch:
  - unit_valid_o = pending_valid && !hazard && free_slot_exists, gated by the selected unit.
  - uop_o = pending request whenever pending_valid, 0 otherwise.
  - dispatch_fire = unit_valid_o && unit_ready_i.
  - valid_o stays asserted with uop_o stable until fire (standard valid/ready, no retraction).
- Allocation: on dispatch_fire, the lowest-index invalid entry is written with insn_id, vs[], use_vs[] and the unit index.
- Latency: request accepted in cycle N is dispatched earliest in cycle N+1.
- Completion:
  - For each done_valid_i[u], the valid entry with matching insn_id and unit==u is invalidated at the clock edge.
  - A done with no matching entry is ignored; in simulation an assertion fires.
  - Up to three frees per cycle.
- Simultaneous free/alloc:
  - Hazard and free-slot decisions use entry state at the start of the cycle; there is no same-cycle bypass.
  - An entry freed in cycle N is usable for hazard clearing and allocation in N+1.
  - Free and alloc of the same index in one cycle cannot occur, because alloc picks only from already-invalid entries.
- Full: with all NrInflight entries valid, no dispatch. The pending request holds and req_ready_o drops until a free occurs.
- No speculation or flush; reset mid-operation discards the pending request and all scoreboard state.
- insn_id uniqueness among in-flight instructions is an upstream guarantee.

Decomposition:
- Add to rvv_pkg:
  - vunit_e (VU_ARITH, VU_LOAD, VU_STORE)
  - NrVUnits=3
  - sb_entry_t {valid, insn_id, vs[3], use_vs[3], unit}
- Sub-module vinsn_scoreboard: entry array, hazard compare, lowest-free allocation, multi-port completion free.
- vinsn_launcher keeps the pending register, unit select and handshake.

Test Plan:
- Independent back-to-back: VADD v1←v2,v3 (id 0), then VADD v4←v5,v6 (id 1), arith_ready_i=1 → both accepted in consecutive cycles; dispatched in cycles 1 and 2; req_ready_o stays 1.
- RAW: VLE v8 (id 0), load never done; then VADD v9←v8,v2 (id 1) → arith_valid_o=0 while id 0 is in flight. done_valid_i[1] with id 0 → arith_valid_o=1 one cycle later.
- WAR/WAW: VSE reads v3 (id 2) outstanding; VLE v3 → stalled until store done id 2. A second VLE v3 while the first is in flight → stalled until load done.
- Full: NrInflight=4 independent VADDs with no completion → 4 dispatches, then the 5th is held with req_ready_o=0. One done frees a slot and the 5th dispatches the next cycle.
- Backpressure: arith_ready_i=0 for 3 cycles → arith_valid_o held at 1 with uop_o stable; req_ready_o=0; single fire when ready returns.
- Reset mid-operation: 2 entries valid plus pending, assert rst_ni=0 asynchronously → busy_o=0 and all valid_o=0 immediately, req_ready_o=1.

Source files
------------

// File: rtl/rvv_pkg.sv
// Shared vector-issue types: decoded request layout, execution-unit
// select and scoreboard entry used by the instruction launcher.
package rvv_pkg;

  typedef enum logic [2:0] {
    VADD = 3'd0,
    VSUB = 3'd1,
    VMUL = 3'd2,
    VLE  = 3'd3,
    VSE  = 3'd4
  } vop_e;

  typedef logic [3:0] insn_id_t;
  typedef logic [4:0] vreg_t;

  // Operand slots inside vs[] / use_vs[]
  localparam int unsigned VD  = 0;
  localparam int unsigned VS1 = 1;
  localparam int unsigned VS2 = 2;

  typedef struct packed {
    vop_e            vop;
    insn_id_t        insn_id;
    vreg_t [2:0]     vs;
    logic  [2:0]     use_vs;
  } issue_req_t;

  localparam int unsigned NrVUnits = 3;

  typedef enum logic [1:0] {
    VU_ARITH = 2'd0,
    VU_LOAD  = 2'd1,
    VU_STORE = 2'd2
  } vunit_e;

  typedef struct packed {
    logic        valid;
    insn_id_t    insn_id;
    vreg_t [2:0] vs;
    logic  [2:0] use_vs;
    vunit_e      unit;
  } sb_entry_t;

endpackage

// File: rtl/vinsn_scoreboard.sv
// In-flight instruction table: vector-register hazard detection against the
// pending request, lowest-free allocation and per-unit completion release.
module vinsn_scoreboard
  import rvv_pkg::*;
#(
  parameter int unsigned NrInflight = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  issue_req_t                    i_req,
  input  logic                          i_alloc,
  input  vunit_e                        i_alloc_unit,
  input  logic     [NrVUnits-1:0]       i_done_valid,
  input  insn_id_t [NrVUnits-1:0]       i_done_id,
  output logic                          o_hazard,
  output logic                          o_free_avail,
  output logic                          o_any_valid
);

  sb_entry_t              r_sb [NrInflight];
  logic [NrInflight-1:0]  w_free_sel;
  logic [NrInflight-1:0]  w_clr;
  logic [NrVUnits-1:0]    w_done_hit;
  logic                   w_found;

  always_comb begin
    o_hazard    = 1'b0;
    o_any_valid = 1'b0;
    w_found     = 1'b0;
    w_free_sel  = '0;
    w_clr       = '0;
    w_done_hit  = '0;
    for (int unsigned e = 0; e < NrInflight; e++) begin
      if (r_sb[e].valid) begin
        o_any_valid = 1'b1;
        if ((i_req.use_vs[VS1] && r_sb[e].use_vs[VD] && (i_req.vs[VS1] == r_sb[e].vs[VD])) ||
            (i_req.use_vs[VS2] && r_sb[e].use_vs[VD] && (i_req.vs[VS2] == r_sb[e].vs[VD])) ||
            (i_req.use_vs[VD]  && r_sb[e].use_vs[VS1] && (r_sb[e].vs[VS1] == i_req.vs[VD])) ||
            (i_req.use_vs[VD]  && r_sb[e].use_vs[VS2] && (r_sb[e].vs[VS2] == i_req.vs[VD])) ||
            (i_req.use_vs[VD]  && r_sb[e].use_vs[VD]  && (r_sb[e].vs[VD]  == i_req.vs[VD])))
          o_hazard = 1'b1;
        for (int unsigned u = 0; u < NrVUnits; u++) begin
          if (i_done_valid[u] && (r_sb[e].insn_id == i_done_id[u]) &&
              (32'(r_sb[e].unit) == u)) begin
            w_clr[e]      = 1'b1;
            w_done_hit[u] = 1'b1;
          end
        end
      end else if (!w_found) begin
        w_free_sel[e] = 1'b1;
        w_found       = 1'b1;
      end
    end
    o_free_avail = w_found;
  end

  // Alloc only targets entries already invalid, so it never collides with a free.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned e = 0; e < NrInflight; e++) r_sb[e] <= '0;
    end else begin
      for (int unsigned e = 0; e < NrInflight; e++) begin
        if (w_clr[e]) begin
          r_sb[e].valid <= 1'b0;
        end else if (i_alloc && w_free_sel[e]) begin
          r_sb[e] <= '{valid:   1'b1,
                       insn_id: i_req.insn_id,
                       vs:      i_req.vs,
                       use_vs:  i_req.use_vs,
                       unit:    i_alloc_unit};
        end
      end
    end
  end

  for (genvar u = 0; u < NrVUnits; u++) begin : g_done_chk
    a_done_match: assert property (@(posedge i_clk) disable iff (!i_rst_n)
                                   i_done_valid[u] |-> w_done_hit[u]);
  end

endmodule

// File: rtl/vinsn_launcher.sv
// Single-entry pending stage between the vector decoder and the execution
// units: holds a request until it is hazard-free and a scoreboard slot exists.
module vinsn_launcher
  import rvv_pkg::*;
#(
  parameter int unsigned NrInflight = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  issue_req_t               issue_req_i,
  output logic                     arith_valid_o,
  input  logic                     arith_ready_i,
  output logic                     load_valid_o,
  input  logic                     load_ready_i,
  output logic                     store_valid_o,
  input  logic                     store_ready_i,
  output issue_req_t               uop_o,
  input  logic     [NrVUnits-1:0]  done_valid_i,
  input  insn_id_t [NrVUnits-1:0]  done_id_i,
  output logic                     busy_o
);

  logic       r_pend_valid;
  issue_req_t r_pend;
  vunit_e     w_unit;
  logic       w_hazard;
  logic       w_free_avail;
  logic       w_any_valid;
  logic       w_can_issue;
  logic       w_fire;

  always_comb begin
    w_unit = VU_ARITH;
    case (r_pend.vop)
      VLE:     w_unit = VU_LOAD;
      VSE:     w_unit = VU_STORE;
      default: w_unit = VU_ARITH;
    endcase
  end

  assign w_can_issue   = r_pend_valid && !w_hazard && w_free_avail;
  assign arith_valid_o = w_can_issue && (w_unit == VU_ARITH);
  assign load_valid_o  = w_can_issue && (w_unit == VU_LOAD);
  assign store_valid_o = w_can_issue && (w_unit == VU_STORE);
  assign w_fire        = (arith_valid_o && arith_ready_i) ||
                         (load_valid_o  && load_ready_i)  ||
                         (store_valid_o && store_ready_i);

  assign req_ready_o = !r_pend_valid || w_fire;
  assign uop_o       = r_pend_valid ? r_pend : '0;
  assign busy_o      = r_pend_valid || w_any_valid;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pend_valid <= 1'b0;
      r_pend       <= '0;
    end else if (req_valid_i && req_ready_o) begin
      r_pend_valid <= 1'b1;
      r_pend       <= issue_req_i;
    end else if (w_fire) begin
      r_pend_valid <= 1'b0;
    end
  end

  vinsn_scoreboard #(
    .NrInflight (NrInflight)
  ) u_sb (
    .i_clk        (clk_i),
    .i_rst_n      (rst_ni),
    .i_req        (r_pend),
    .i_alloc      (w_fire),
    .i_alloc_unit (w_unit),
    .i_done_valid (done_valid_i),
    .i_done_id    (done_id_i),
    .o_hazard     (w_hazard),
    .o_free_avail (w_free_avail),
    .o_any_valid  (w_any_valid)
  );

endmodule

// File: tb/tb_vinsn_launcher.sv
// Scoreboard bench for vinsn_launcher: accepted requests are queued with their
// expected target unit and matched in order against observed dispatches.
module tb_vinsn_launcher;
  import rvv_pkg::*;

  localparam int unsigned NrInflight = 4;

  logic                    clk;
  logic                    rst_n;
  logic                    req_valid;
  logic                    req_ready;
  issue_req_t              issue_req;
  logic                    arith_valid, arith_ready;
  logic                    load_valid, load_ready;
  logic                    store_valid, store_ready;
  issue_req_t              uop;
  logic     [NrVUnits-1:0] done_valid;
  insn_id_t [NrVUnits-1:0] done_id;
  logic                    busy;

  vinsn_launcher #(
    .NrInflight (NrInflight)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .issue_req_i   (issue_req),
    .arith_valid_o (arith_valid),
    .arith_ready_i (arith_ready),
    .load_valid_o  (load_valid),
    .load_ready_i  (load_ready),
    .store_valid_o (store_valid),
    .store_ready_i (store_ready),
    .uop_o         (uop),
    .done_valid_i  (done_valid),
    .done_id_i     (done_id),
    .busy_o        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    issue_req_t req;
    vunit_e     unit;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  int   n_fire = 0;
  int   fire_cyc [16];
  int   acc0, acc1, acc_tmp, f0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic issue_req_t mk(input vop_e op, input int id, input int vd,
                                    input int vs1, input int vs2, input logic [2:0] uv);
    issue_req_t r;
    r          = '0;
    r.vop      = op;
    r.insn_id  = insn_id_t'(id);
    r.vs[VD]   = vreg_t'(vd);
    r.vs[VS1]  = vreg_t'(vs1);
    r.vs[VS2]  = vreg_t'(vs2);
    r.use_vs   = uv;
    return r;
  endfunction

  function automatic vunit_e unit_of(input vop_e op);
    if (op == VLE) return VU_LOAD;
    if (op == VSE) return VU_STORE;
    return VU_ARITH;
  endfunction

  always @(posedge clk) cyc++;

  logic   w_fire;
  vunit_e w_unit_got;
  assign w_fire = (arith_valid && arith_ready) || (load_valid && load_ready) ||
                  (store_valid && store_ready);
  assign w_unit_got = arith_valid ? VU_ARITH : (load_valid ? VU_LOAD : VU_STORE);

  always @(negedge clk) begin
    if (rst_n && w_fire) begin
      chk("valid_onehot", 32'($countones({arith_valid, load_valid, store_valid})), 1);
      if (q.size() == 0) begin
        chk("unexpected_dispatch", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("disp_uop", uop, e.req);
        chk("disp_unit", w_unit_got, e.unit);
        fire_cyc[uop.insn_id] = cyc;
        n_fire++;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input issue_req_t r, output int acc);
    logic got;
    got       = 1'b0;
    acc       = -1;
    req_valid = 1'b1;
    issue_req = r;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (req_ready) got = 1'b1;
    end
    if (!got) begin
      chk("send_timeout", 0, 1);
    end else begin
      q.push_back('{req: r, unit: unit_of(r.vop)});
      acc = cyc;
    end
    tick();
    req_valid = 1'b0;
    issue_req = '0;
  endtask

  task automatic done(input int u, input int id);
    done_valid[u] = 1'b1;
    done_id[u]    = insn_id_t'(id);
    tick();
    done_valid = '0;
    done_id    = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n       = 1'b0;
    req_valid   = 1'b0;
    issue_req   = '0;
    arith_ready = 1'b1;
    load_ready  = 1'b1;
    store_ready = 1'b1;
    done_valid  = '0;
    done_id     = '0;

    // Reset state
    @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_valids", {arith_valid, load_valid, store_valid}, 3'b000);
    chk("rst_busy", busy, 0);
    chk("rst_uop", uop, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Independent back-to-back VADDs
    send(mk(VADD, 0, 1, 2, 3, 3'b111), acc0);
    send(mk(VADD, 1, 4, 5, 6, 3'b111), acc1);
    repeat (2) tick();
    chk("b2b_accept_gap", 32'(acc1 - acc0), 1);
    chk("b2b_first_latency", 32'(fire_cyc[0] - acc0), 1);
    chk("b2b_disp_gap", 32'(fire_cyc[1] - fire_cyc[0]), 1);
    done(0, 0);
    done(0, 1);
    @(negedge clk);
    chk("b2b_idle_busy", busy, 0);
    tick();

    // RAW: VADD reads v8 written by outstanding VLE
    send(mk(VLE, 0, 8, 0, 0, 3'b001), acc_tmp);
    send(mk(VADD, 1, 9, 8, 2, 3'b111), acc_tmp);
    repeat (3) tick();
    @(negedge clk);
    chk("raw_stall", arith_valid, 0);
    chk("raw_hold_ready", req_ready, 0);
    done(1, 0);
    @(negedge clk);
    chk("raw_release", arith_valid, 1);
    tick();
    tick();
    done(0, 1);

    // WAR: VLE v3 behind store reading v3; then WAW on v3
    send(mk(VSE, 2, 0, 3, 0, 3'b010), acc_tmp);
    send(mk(VLE, 3, 3, 0, 0, 3'b001), acc_tmp);
    repeat (3) tick();
    @(negedge clk);
    chk("war_stall", load_valid, 0);
    done(2, 2);
    @(negedge clk);
    chk("war_release", load_valid, 1);
    tick();
    send(mk(VLE, 4, 3, 0, 0, 3'b001), acc_tmp);
    repeat (2) tick();
    @(negedge clk);
    chk("waw_stall", load_valid, 0);
    done(1, 3);
    @(negedge clk);
    chk("waw_release", load_valid, 1);
    tick();
    tick();
    done(1, 4);

    // Full scoreboard: 4 in flight, 5th held
    for (int k = 0; k < 5; k++)
      send(mk(VADD, 5 + k, 10 + 3 * k, 11 + 3 * k, 12 + 3 * k, 3'b111), acc_tmp);
    tick();
    @(negedge clk);
    chk("full_stall", arith_valid, 0);
    chk("full_ready", req_ready, 0);
    chk("full_busy", busy, 1);
    tick();
    done(0, 5);
    @(negedge clk);
    chk("full_release", arith_valid, 1);
    tick();
    tick();
    for (int k = 6; k < 10; k++) done(0, k);

    // Backpressure: ready low for 3 cycles
    arith_ready = 1'b0;
    send(mk(VMUL, 10, 20, 21, 22, 3'b111), acc_tmp);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_valid", arith_valid, 1);
      chk("bp_uop", uop, mk(VMUL, 10, 20, 21, 22, 3'b111));
      chk("bp_ready", req_ready, 0);
      tick();
    end
    f0 = n_fire;
    arith_ready = 1'b1;
    tick();
    chk("bp_single_fire", 32'(n_fire - f0), 1);
    @(negedge clk);
    chk("bp_after_valid", arith_valid, 0);
    tick();
    done(0, 10);

    // Asynchronous reset with two entries in flight plus a held request
    send(mk(VADD, 11, 1, 2, 3, 3'b111), acc_tmp);
    send(mk(VSUB, 12, 4, 5, 6, 3'b111), acc_tmp);
    tick();
    tick();
    arith_ready = 1'b0;
    send(mk(VADD, 13, 7, 8, 9, 3'b111), acc_tmp);
    @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_valid", arith_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_valids", {arith_valid, load_valid, store_valid}, 3'b000);
    chk("arst_ready", req_ready, 1);
    chk("arst_uop", uop, 0);
    q.delete();
    tick();
    rst_n       = 1'b1;
    arith_ready = 1'b1;
    tick();
    @(negedge clk);
    chk("post_rst_busy", busy, 0);
    tick();

    chk("queue_empty", 32'(q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
